// File: rtl/bcd_updown_counter_pkg.sv
// Shared constants, types and digit helpers for the BCD up/down counter.
package bcd_updown_counter_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  localparam nibble_t BCD_MAX = 4'd9;
  localparam nibble_t BCD_MIN = 4'd0;

  // Count direction as carried on the 'up' pin.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Per-edge operation selected for a single decade (reset handled separately).
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_COUNT = 2'd1,
    OP_LOAD  = 2'd2
  } digit_op_e;

  // True when a nibble is outside the decimal range.
  function automatic logic bcd_illegal(input nibble_t n);
    return (n > BCD_MAX);
  endfunction

  // Clamp a nibble into the decimal range; 0xA..0xF become 9.
  function automatic nibble_t bcd_sanitise(input nibble_t n);
    return bcd_illegal(n) ? BCD_MAX : n;
  endfunction

  // One decimal step with wrap. An out-of-range value (only possible before
  // the first reset) is steered back into range rather than propagated.
  function automatic nibble_t bcd_step(input nibble_t n, input dir_e dir);
    nibble_t r;
    if (dir == DIR_UP) begin
      r = (n >= BCD_MAX) ? BCD_MIN : nibble_t'(n + 4'd1);
    end else begin
      r = ((n == BCD_MIN) || bcd_illegal(n)) ? BCD_MAX : nibble_t'(n - 4'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// Single decimal decade: load, count up/down with wrap, terminal count and
// cascade enable for the next decade.
module bcd_digit
  import bcd_updown_counter_pkg::*;
(
  input  logic                clk,
  input  logic                r,
  input  logic                ce,
  input  logic                up,
  input  logic                ld,
  input  logic [NIBBLE_W-1:0] d,
  output logic [NIBBLE_W-1:0] q,
  output logic                tc,
  output logic                ceo
);

  nibble_t   q_q;
  nibble_t   q_d;
  digit_op_e op;
  dir_e      dir;

  assign dir = dir_e'(up);

  // Load has priority over counting; reset is applied in the register.
  always_comb begin
    op = OP_HOLD;
    if (ld) begin
      op = OP_LOAD;
    end else if (ce) begin
      op = OP_COUNT;
    end
  end

  // Next digit value for the selected operation.
  always_comb begin
    q_d = q_q;
    case (op)
      OP_LOAD:  q_d = bcd_sanitise(d);
      OP_COUNT: q_d = bcd_step(q_q, dir);
      default:  q_d = q_q;
    endcase
  end

  // Digit register with synchronous reset to zero.
  always_ff @(posedge clk) begin
    if (r) begin
      q_q <= BCD_MIN;
    end else begin
      q_q <= q_d;
    end
  end

  assign q   = q_q;
  assign tc  = (dir == DIR_UP) ? (q_q == BCD_MAX) : (q_q == BCD_MIN);
  assign ceo = ce & tc;

endmodule

// File: rtl/bcd_updown_counter.sv
// Cascaded BCD up/down counter: DIGITS decades chained by ceo -> ce, with
// load sanitising, load-error flag and combinational TC/CEO.
module bcd_updown_counter
  import bcd_updown_counter_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                         clk,
  input  logic                         r,
  input  logic                         ce,
  input  logic                         up,
  input  logic                         ld,
  input  logic [NIBBLE_W*DIGITS-1:0]   din,
  output logic [NIBBLE_W*DIGITS-1:0]   Q,
  output logic                         TC,
  output logic                         CEO,
  output logic                         LERR
);

  logic [NIBBLE_W*DIGITS-1:0] din_s;
  logic [DIGITS-1:0]          illegal;
  logic [DIGITS-1:0]          tc_vec;
  logic [DIGITS:0]            ce_chain;
  logic                       lerr_q;
  logic                       lerr_d;

  // Clamp every load nibble into BCD range and note which ones were illegal.
  always_comb begin
    din_s   = '0;
    illegal = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      din_s[k*NIBBLE_W +: NIBBLE_W] = bcd_sanitise(din[k*NIBBLE_W +: NIBBLE_W]);
      illegal[k]                    = bcd_illegal(din[k*NIBBLE_W +: NIBBLE_W]);
    end
  end

  assign ce_chain[0] = ce;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
        .clk (clk),
        .r   (r),
        .ce  (ce_chain[g]),
        .up  (up),
        .ld  (ld),
        .d   (din_s[g*NIBBLE_W +: NIBBLE_W]),
        .q   (Q[g*NIBBLE_W +: NIBBLE_W]),
        .tc  (tc_vec[g]),
        .ceo (ce_chain[g+1])
      );
    end
  endgenerate

  // Error flag is set only by a load carrying an illegal nibble.
  always_comb begin
    lerr_d = ld & (|illegal);
  end

  // Load-error register, cleared by reset and by every non-offending edge.
  always_ff @(posedge clk) begin
    if (r) begin
      lerr_q <= 1'b0;
    end else begin
      lerr_q <= lerr_d;
    end
  end

  assign LERR = lerr_q;
  assign TC   = &tc_vec;
  // The tail of the enable chain is ce AND every digit's tc, i.e. ce AND TC.
  assign CEO  = ce_chain[DIGITS];

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench for bcd_updown_counter (DIGITS=4 and DIGITS=2 instances)
// against an integer-arithmetic reference model.
module tb_bcd_updown_counter;

  logic        clk;
  logic        r4, ce4, up4, ld4;
  logic [15:0] din4, Q4;
  logic        TC4, CEO4, LERR4;
  logic        r2, ce2, up2, ld2;
  logic [7:0]  din2, Q2;
  logic        TC2, CEO2, LERR2;

  int total;
  int bad;

  int m4, m2;
  bit l4, l2;

  bcd_updown_counter #(.DIGITS(4)) u_dut4 (
    .clk(clk), .r(r4), .ce(ce4), .up(up4), .ld(ld4), .din(din4),
    .Q(Q4), .TC(TC4), .CEO(CEO4), .LERR(LERR4)
  );

  bcd_updown_counter #(.DIGITS(2)) u_dut2 (
    .clk(clk), .r(r2), .ce(ce2), .up(up2), .ld(ld2), .din(din2),
    .Q(Q2), .TC(TC2), .CEO(CEO2), .LERR(LERR2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] int2bcd(input int v);
    logic [31:0] b;
    int t;
    b = '0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      b[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  function automatic int bcd2int(input logic [31:0] b, input int nd);
    int v;
    int nib;
    v = 0;
    for (int i = nd - 1; i >= 0; i--) begin
      nib = int'(b[i*4 +: 4]);
      if (nib > 9) nib = 9;
      v = v * 10 + nib;
    end
    return v;
  endfunction

  function automatic bit has_illegal(input logic [31:0] b, input int nd);
    bit f;
    f = 1'b0;
    for (int i = 0; i < nd; i++) begin
      if (int'(b[i*4 +: 4]) > 9) f = 1'b1;
    end
    return f;
  endfunction

  function automatic logic [18:0] exp4();
    logic [31:0] b;
    logic tc;
    b  = int2bcd(m4);
    tc = up4 ? (m4 == 9999) : (m4 == 0);
    return {b[15:0], tc, ce4 & tc, l4};
  endfunction

  function automatic logic [10:0] exp2();
    logic [31:0] b;
    logic tc;
    b  = int2bcd(m2);
    tc = up2 ? (m2 == 99) : (m2 == 0);
    return {b[7:0], tc, ce2 & tc, l2};
  endfunction

  // Advance both models by the rules of one edge, then let the edge happen.
  task automatic tick();
    if (r4) begin
      m4 = 0; l4 = 1'b0;
    end else if (ld4) begin
      m4 = bcd2int(32'(din4), 4); l4 = has_illegal(32'(din4), 4);
    end else begin
      l4 = 1'b0;
      if (ce4) m4 = up4 ? (m4 + 1) % 10000 : (m4 + 9999) % 10000;
    end
    if (r2) begin
      m2 = 0; l2 = 1'b0;
    end else if (ld2) begin
      m2 = bcd2int(32'(din2), 2); l2 = has_illegal(32'(din2), 2);
    end else begin
      l2 = 1'b0;
      if (ce2) m2 = up2 ? (m2 + 1) % 100 : (m2 + 99) % 100;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle4();
    r4 = 1'b0; ld4 = 1'b0; ce4 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [18:0] e4;
    r4 = 1'b1; ld4 = 1'b1; ce4 = 1'b1; up4 = 1'b0; din4 = 16'h5A55;
    r2 = 1'b1; ld2 = 1'b0; ce2 = 1'b1; up2 = 1'b1; din2 = 8'h00;
    tick();
    if (Q4 !== 16'h0000 || LERR4 !== 1'b0) begin
      bad++; $display("FAIL reset_q4 got Q=%h LERR=%b exp Q=0000 LERR=0", Q4, LERR4);
    end
    total++;
    if (TC4 !== 1'b1) begin
      bad++; $display("FAIL reset_tc_down got %b exp 1", TC4);
    end
    total++;
    if (Q2 !== 8'h00) begin
      bad++; $display("FAIL reset_q2 got %h exp 00", Q2);
    end
    total++;
    up4 = 1'b1;
    #1;
    e4 = exp4();
    if (TC4 !== 1'b0 || {Q4, TC4, CEO4, LERR4} !== e4) begin
      bad++; $display("FAIL reset_tc_up got %h exp %h", {Q4, TC4, CEO4, LERR4}, e4);
    end
    total++;
    idle4(); r2 = 1'b0; ce2 = 1'b0;
  endtask

  task automatic test_count_up_2();
    logic [10:0] e2;
    r2 = 1'b1; tick();
    r2 = 1'b0; ce2 = 1'b1; up2 = 1'b1; ld2 = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      e2 = exp2();
      if ({Q2, TC2, CEO2, LERR2} !== e2 || TC2 !== ((i % 100) == 99)) begin
        bad++; $display("FAIL count_up_2 cyc=%0d got %h exp %h", i, {Q2, TC2, CEO2, LERR2}, e2);
      end
      total++;
    end
    if (Q2 !== 8'h00) begin
      bad++; $display("FAIL count_up_2_wrap got %h exp 00", Q2);
    end
    total++;
    ce2 = 1'b0;
  endtask

  task automatic test_load_down_2();
    ld2 = 1'b1; din2 = 8'h00; up2 = 1'b0; ce2 = 1'b1;
    tick();
    if (Q2 !== 8'h00 || TC2 !== 1'b1 || CEO2 !== 1'b1) begin
      bad++; $display("FAIL load_down_2_ld got Q=%h TC=%b CEO=%b exp 00 1 1", Q2, TC2, CEO2);
    end
    total++;
    ld2 = 1'b0;
    tick();
    if (Q2 !== 8'h99 || {Q2, TC2, CEO2, LERR2} !== exp2()) begin
      bad++; $display("FAIL load_down_2_99 got %h exp 99", Q2);
    end
    total++;
    tick();
    if (Q2 !== 8'h98) begin
      bad++; $display("FAIL load_down_2_98 got %h exp 98", Q2);
    end
    total++;
    ce2 = 1'b0;
  endtask

  task automatic test_load_illegal();
    idle4(); up4 = 1'b1; ld4 = 1'b1; din4 = 16'h1A3F;
    tick();
    if (Q4 !== 16'h1939 || LERR4 !== 1'b1) begin
      bad++; $display("FAIL load_illegal got Q=%h LERR=%b exp 1939 1", Q4, LERR4);
    end
    total++;
    ld4 = 1'b0;
    tick();
    if (Q4 !== 16'h1939 || LERR4 !== 1'b0) begin
      bad++; $display("FAIL load_illegal_clear got Q=%h LERR=%b exp 1939 0", Q4, LERR4);
    end
    total++;
  endtask

  task automatic test_carry();
    idle4(); ld4 = 1'b1; din4 = 16'h0999;
    tick();
    ld4 = 1'b0; ce4 = 1'b1; up4 = 1'b1;
    tick();
    if (Q4 !== 16'h1000 || {Q4, TC4, CEO4, LERR4} !== exp4()) begin
      bad++; $display("FAIL carry_up got %h exp 1000", Q4);
    end
    total++;
    up4 = 1'b0;
    tick();
    if (Q4 !== 16'h0999) begin
      bad++; $display("FAIL borrow_down got %h exp 0999", Q4);
    end
    total++;
    idle4();
  endtask

  task automatic test_priority();
    idle4(); ld4 = 1'b1; din4 = 16'h0457;
    tick();
    r4 = 1'b1; ld4 = 1'b1; ce4 = 1'b1; din4 = 16'hFFFF;
    tick();
    if (Q4 !== 16'h0000 || LERR4 !== 1'b0) begin
      bad++; $display("FAIL prio_reset got Q=%h LERR=%b exp 0000 0", Q4, LERR4);
    end
    total++;
    r4 = 1'b0; ld4 = 1'b1; ce4 = 1'b1; up4 = 1'b1; din4 = 16'h0123;
    tick();
    if (Q4 !== 16'h0123 || LERR4 !== 1'b0) begin
      bad++; $display("FAIL prio_load_over_ce got Q=%h exp 0123", Q4);
    end
    total++;
    idle4();
  endtask

  task automatic test_hold();
    idle4(); ld4 = 1'b1; din4 = 16'h0042;
    tick();
    ld4 = 1'b0; ce4 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      up4 = ~up4;
      tick();
      if (Q4 !== 16'h0042 || CEO4 !== 1'b0) begin
        bad++; $display("FAIL hold cyc=%0d got Q=%h CEO=%b exp 0042 0", i, Q4, CEO4);
      end
      total++;
    end
  endtask

  task automatic test_dir_change();
    idle4(); up4 = 1'b0; ld4 = 1'b1; din4 = 16'h0000;
    tick();
    ld4 = 1'b0;
    if (TC4 !== 1'b1) begin
      bad++; $display("FAIL dir_tc_down got %b exp 1", TC4);
    end
    total++;
    up4 = 1'b1;
    #1;
    if (TC4 !== 1'b0) begin
      bad++; $display("FAIL dir_tc_immediate got %b exp 0", TC4);
    end
    total++;
    ce4 = 1'b1;
    tick();
    if (Q4 !== 16'h0001) begin
      bad++; $display("FAIL dir_first_up got %h exp 0001", Q4);
    end
    total++;
    up4 = 1'b0;
    tick();
    tick();
    if (Q4 !== 16'h9999 || TC4 !== 1'b0) begin
      bad++; $display("FAIL full_wrap_down got Q=%h TC=%b exp 9999 0", Q4, TC4);
    end
    total++;
    up4 = 1'b1;
    tick();
    if (Q4 !== 16'h0000) begin
      bad++; $display("FAIL full_wrap_up got %h exp 0000", Q4);
    end
    total++;
    idle4();
  endtask

  task automatic test_random();
    logic [18:0] e4;
    logic [10:0] e2;
    int sel;
    for (int i = 0; i < 800; i++) begin
      r4  = ($urandom_range(0, 63) == 0);
      ld4 = ($urandom_range(0, 11) == 0);
      ce4 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) up4 = ~up4;
      sel = int'($urandom_range(0, 3));
      din4 = (sel == 0) ? 16'h9998 : (sel == 1) ? 16'h0001 : 16'($urandom);
      r2  = ($urandom_range(0, 63) == 0);
      ld2 = ($urandom_range(0, 11) == 0);
      ce2 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) up2 = ~up2;
      din2 = 8'($urandom);
      tick();
      e4 = exp4();
      if ({Q4, TC4, CEO4, LERR4} !== e4) begin
        bad++; $display("FAIL random4 cyc=%0d got %h exp %h", i, {Q4, TC4, CEO4, LERR4}, e4);
      end
      total++;
      e2 = exp2();
      if ({Q2, TC2, CEO2, LERR2} !== e2) begin
        bad++; $display("FAIL random2 cyc=%0d got %h exp %h", i, {Q2, TC2, CEO2, LERR2}, e2);
      end
      total++;
    end
    idle4(); r2 = 1'b0; ld2 = 1'b0; ce2 = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    m4 = 0; m2 = 0; l4 = 1'b0; l2 = 1'b0;
    r4 = 1'b1; ce4 = 1'b0; up4 = 1'b0; ld4 = 1'b0; din4 = '0;
    r2 = 1'b1; ce2 = 1'b0; up2 = 1'b0; ld2 = 1'b0; din2 = '0;
    #2;
    test_reset();
    test_count_up_2();
    test_load_down_2();
    test_load_illegal();
    test_carry();
    test_priority();
    test_hold();
    test_dir_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 4, number of cascaded decimal decades (legal 1..8).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 r  input  1  reset, synchronous, active-high.
REQ-004 ce  input  1  count enable.
REQ-005 up  input  1  direction: 1 = count up, 0 = count down.
REQ-006 ld  input  1  synchronous parallel load strobe.
REQ-007 din  input  4*DIGITS  load value, one BCD digit per nibble, LSD in bits [3:0].
REQ-008 Q  output  4*DIGITS  counter value, BCD, LSD in bits [3:0].
REQ-009 TC  output  1  terminal count: all digits 9 when up=1, all digits 0 when up=0; combinational from Q and up.
REQ-010 CEO  output  1  cascade enable out = ce AND TC.
REQ-011 LERR  output  1  registered flag: last load contained a non-BCD nibble.

Function
REQ-012 Priority per edge SHALL be r > ld > ce; with none active, Q holds.
REQ-013 ld=1: each nibble of din SHALL load into its digit; any nibble 0xA..0xF SHALL load as 9 and LERR SHALL be set to 1 for that cycle.
REQ-014 LERR SHALL be 0 after any edge that is not a load with an illegal nibble.
REQ-015 ce=1, up=1: LSD increments; digit k increments only if digits 0..k-1 are all 9; a digit at 9 that increments SHALL wrap to 0.
REQ-016 ce=1, up=0: LSD decrements; digit k decrements only if digits 0..k-1 are all 0; a digit at 0 that decrements SHALL wrap to 9.
REQ-017 Full wrap: all-9 up -> all-0; all-0 down -> all-9, in one cycle.
REQ-018 Latency: Q SHALL reflect count/load/reset one cycle after the sampling edge; TC and CEO SHALL follow Q, up and ce with no register stage.
REQ-019 Changing up between edges SHALL take effect on the next edge, no dead cycle; TC SHALL re-evaluate immediately.
REQ-020 Q SHALL never hold a non-BCD nibble under any input sequence.
REQ-021 ld and ce both high: load wins, no count that cycle.

Reset
REQ-022 r=1 at an edge SHALL set Q=0 and LERR=0 regardless of ld, ce, up.
REQ-023 Reset mid-count or coincident with load SHALL discard the operation; counting resumes from 0 on the first edge with r=0 and ce=1.
REQ-024 After reset with up=0, TC SHALL be 1; with up=1, TC SHALL be 0.

Structure
REQ-025 Shared package SHALL hold BCD_MAX (4'd9), BCD_MIN (4'd0) and the nibble width constant (4).
REQ-026 One sub-module bcd_digit SHALL implement a single decade (inputs clk, r, ce, up, ld, d; outputs q, tc, ceo); the top SHALL generate DIGITS instances chained ceo -> ce.
REQ-027 The top SHALL contain only the generate chain, load sanitising, LERR register and TC/CEO gating.

Verification
REQ-028 DIGITS=2, r pulse then ce=1, up=1 for 100 cycles -> Q steps 00..99, TC=1 only at 99, CEO=1 there, Q=00 on cycle 100.
REQ-029 DIGITS=2, ld din=0x00, up=0, ce=1 -> TC=1 at load, next edge Q=0x99, then 0x98.
REQ-030 DIGITS=4, ld din=0x1A3F -> Q=0x1939, LERR=1 one cycle then 0.
REQ-031 DIGITS=4, Q=0x0999, up=1, ce=1 -> Q=0x1000 in one edge; up=0 from 0x1000 -> 0x0999.
REQ-032 ld=1, ce=1, r=1 same edge at Q=0x0457 -> Q=0x0000, LERR=0; ld+ce without r, din=0x0123 -> Q=0x0123 (no increment).
REQ-033 ce=0 for 10 cycles at Q=0x0042 with up toggling -> Q stays 0x0042, CEO=0 throughout.
